// File: rtl/tc_counter_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tc_counter_arbiter_pkg
//  Purpose  : Shared types for the round-robin counter arbiter.
//             - state_t  : 2-bit arbiter FSM state
//             - WHY_*    : codes reported on done_why
//             - LEASE_W  : width of the internal lease down-counter
//  Revision : 1.0  initial release
// ============================================================================
package tc_counter_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] WHY_DROP  = 2'd0;  // owner dropped its request
  localparam logic [1:0] WHY_LEASE = 2'd1;  // lease ran out

  localparam int LEASE_W = 16;

endpackage : tc_counter_arbiter_pkg
`default_nettype wire

// File: rtl/tc_counter_core.sv
`default_nettype none
// ============================================================================
//  Module   : tc_counter_core
//  Purpose  : SIZE-bit counter. When save is high the counter takes in,
//             otherwise it increments by one (wrapping silently).
//  Ports    : clk   - rising-edge clock
//             rst   - asynchronous active-low reset (count -> 0)
//             save  - 1: load in, 0: increment
//             in    - value loaded when save is high
//             count - current counter value (registered)
//  Revision : 1.0  initial release
// ============================================================================
module tc_counter_core #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            save,
  input  logic [SIZE-1:0] in,
  output logic [SIZE-1:0] count
);

  logic [SIZE-1:0] count_q;
  logic [SIZE-1:0] count_d;

  always_comb begin
    count_d = count_q + SIZE'(1);
    if (save) begin
      count_d = in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : tc_counter_core
`default_nettype wire

// File: rtl/tc_counter_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tc_counter_arbiter
//  Purpose  : Round-robin arbiter that leases a shared counter to one of NREQ
//             requesters. The owner's load value seeds the counter, which
//             then counts up until the owner drops its request or the lease
//             (LEASE cycles of RUN) expires.
//  Ports    : clk      - rising-edge clock
//             rst      - asynchronous active-low reset
//             req      - per-requester level request
//             load_val - per-requester start value, slot i at [i*SIZE +: SIZE]
//             grant    - one-hot current owner (registered)
//             count    - shared counter value (registered)
//             tc       - terminal count: RUN and count all ones (combinational)
//             done     - one-cycle pulse while in RELEASE
//             done_id  - owner index, valid with done
//             done_why - exit cause, valid with done (WHY_DROP / WHY_LEASE)
//  Revision : 1.0  initial release
// ============================================================================
module tc_counter_arbiter
  import tc_counter_arbiter_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int NREQ  = 4,
  parameter int LEASE = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*SIZE-1:0]     load_val,
  output logic [NREQ-1:0]          grant,
  output logic [SIZE-1:0]          count,
  output logic                     tc,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [1:0]               done_why
);

  localparam int IDW = $clog2(NREQ);

  state_t               state_q, state_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [IDW-1:0]       last_owner_q, last_owner_d;
  logic [LEASE_W-1:0]   lease_q, lease_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic                 done_q, done_d;
  logic [IDW-1:0]       done_id_q, done_id_d;
  logic [1:0]           done_why_q, done_why_d;

  logic                 cnt_save;
  logic [SIZE-1:0]      cnt_in;

  // Round-robin pick: scan from last_owner+1, wrapping, first request wins.
  // cand is one bit wider so last_owner + NREQ never overflows before wrap.
  logic                 found;
  logic [IDW-1:0]       winner;
  logic [IDW:0]         cand;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_owner_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && req[cand[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
  end

  logic run_drop;
  logic run_expired;

  assign run_drop    = !req[owner_q];
  assign run_expired = (lease_q == '0);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    lease_d      = lease_q;
    grant_d      = grant_q;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    done_why_d   = done_why_q;
    cnt_save     = 1'b1;
    cnt_in       = count;  // hold unless a state says otherwise

    unique case (state_q)
      ST_IDLE: begin
        cnt_in  = '0;
        grant_d = '0;
        if (found) begin
          state_d = ST_LOAD;
          owner_d = winner;
          grant_d = NREQ'(1) << winner;
        end
      end
      ST_LOAD: begin
        cnt_in  = load_val[owner_q*SIZE +: SIZE];
        lease_d = LEASE_W'(LEASE - 1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (run_drop || run_expired) begin
          // Exit edge: counter holds its last RUN value into RELEASE.
          // A request drop takes priority over lease expiry.
          state_d    = ST_RELEASE;
          grant_d    = '0;
          done_d     = 1'b1;
          done_id_d  = owner_q;
          done_why_d = run_drop ? WHY_DROP : WHY_LEASE;
        end else begin
          cnt_save = 1'b0;
          lease_d  = lease_q - LEASE_W'(1);
        end
      end
      ST_RELEASE: begin
        last_owner_d = owner_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= IDW'(NREQ - 1);  // requester 0 wins first after reset
      lease_q      <= '0;
      grant_q      <= '0;
      done_q       <= 1'b0;
      done_id_q    <= '0;
      done_why_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      lease_q      <= lease_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      done_why_q   <= done_why_d;
    end
  end

  tc_counter_core #(
    .SIZE (SIZE)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .save  (cnt_save),
    .in    (cnt_in),
    .count (count)
  );

  assign grant    = grant_q;
  assign done     = done_q;
  assign done_id  = done_id_q;
  assign done_why = done_why_q;
  assign tc       = (state_q == ST_RUN) && (&count);

endmodule : tc_counter_arbiter
`default_nettype wire

// File: tb/tb_tc_counter_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tc_counter_arbiter
//  Purpose  : Scoreboard bench for tc_counter_arbiter (SIZE=8, NREQ=4,
//             LEASE=16). Stimulus computes each lease outcome from the
//             arbitration/lease rules and queues it; a monitor compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tc_counter_arbiter;

  localparam int SIZE  = 8;
  localparam int NREQ  = 4;
  localparam int LEASE = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] load_val;
  logic [NREQ-1:0]      grant;
  logic [SIZE-1:0]      count;
  logic                 tc;
  logic                 done;
  logic [1:0]           done_id;
  logic [1:0]           done_why;

  tc_counter_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .LEASE(LEASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .load_val (load_val),
    .grant    (grant),
    .count    (count),
    .tc       (tc),
    .done     (done),
    .done_id  (done_id),
    .done_why (done_why)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] g;
    logic [SIZE-1:0] start;
  } grant_exp_t;

  typedef struct {
    int              id;
    int              why;
    logic [SIZE-1:0] cnt;
  } done_exp_t;

  grant_exp_t gq[$];
  done_exp_t  dq[$];

  int checks     = 0;
  int failures   = 0;
  int model_last = NREQ - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last + k) % NREQ;
      if (m[idx]) return idx;
    end
    return 0;
  endfunction

  // ---------------------------------------------------------------- monitor
  logic            in_lease = 1'b0;
  logic [SIZE-1:0] exp_cnt  = '0;
  grant_exp_t      ge;
  done_exp_t       de;

  always @(negedge clk) begin
    if (!rst) begin
      in_lease = 1'b0;
    end else begin
      if (grant != '0) begin
        if (!in_lease) begin
          in_lease = 1'b1;
          if (gq.size() == 0) begin
            chk("unexpected_grant", 32'(grant), 32'd0);
          end else begin
            ge = gq.pop_front();
            chk("grant", 32'(grant), 32'(ge.g));
            chk("load_cycle_count", 32'(count), 32'd0);
            exp_cnt = ge.start;
          end
          chk("tc_load", 32'(tc), 32'd0);
        end else begin
          chk("run_count", 32'(count), 32'(exp_cnt));
          chk("tc_run", 32'(tc), 32'(exp_cnt == '1));
          exp_cnt = exp_cnt + 1'b1;
        end
      end else begin
        in_lease = 1'b0;
        chk("tc_not_run", 32'(tc), 32'd0);
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          de = dq.pop_front();
          chk("done_id", 32'(done_id), 32'(de.id));
          chk("done_why", 32'(done_why), 32'(de.why));
          chk("done_count", 32'(count), 32'(de.cnt));
        end
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  // d: RUN cycle (1-based) at whose end req[owner] is first sampled low;
  //    d<=0 drops during LOAD, d>LEASE never drops.
  task automatic do_round(input logic [NREQ-1:0] mask, input logic [NREQ*SIZE-1:0] lv,
                          input int d, input int exp_wait);
    int              w, eff, why, rc, waited, c;
    logic [SIZE-1:0] st, fin;
    logic [NREQ-1:0] ob;
    grant_exp_t      gx;
    done_exp_t       dx;
    w   = rr_pick(model_last, mask);
    st  = lv[w*SIZE +: SIZE];
    eff = (d < 1) ? 1 : d;
    if (eff <= LEASE) begin why = 0; rc = eff;   end
    else              begin why = 1; rc = LEASE; end
    fin = st + SIZE'(rc - 1);
    gx.g = NREQ'(1) << w;  gx.start = st;
    dx.id = w;  dx.why = why;  dx.cnt = fin;
    gq.push_back(gx);
    dq.push_back(dx);
    model_last = w;
    ob = NREQ'(1) << w;

    load_val = lv;
    req      = mask;
    waited   = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (grant == '0 && waited < 10);
    chk("grant_latency", 32'(waited), 32'(exp_wait));
    if (grant == '0) return;

    req = (req & ob) | (NREQ'($urandom) & ~ob);
    if (d <= 0) req = req & ~ob;
    c = 0;
    forever begin
      @(negedge clk);
      c++;
      if (done) break;
      if (c > LEASE + 8) begin
        chk("done_timeout", 32'(done), 32'd1);
        break;
      end
      req = (req & ob) | (NREQ'($urandom) & ~ob);
      if (c == d) req = req & ~ob;
    end
    if (done) chk("done_timing", 32'(c), 32'(rc + 1));
  endtask

  function automatic logic [NREQ*SIZE-1:0] rand_lv();
    logic [NREQ*SIZE-1:0] v;
    v = NREQ*SIZE'($urandom);
    for (int i = 0; i < NREQ; i++) begin
      if ($urandom_range(0, 2) == 0) v[i*SIZE +: SIZE] = 8'hF0 | SIZE'($urandom_range(0, 15));
    end
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ*SIZE-1:0] lv;
    int                   gap;
    int                   ew;
    rst      = 1'b0;
    req      = '0;
    load_val = '0;
    repeat (3) @(negedge clk);
    chk("reset_grant",    32'(grant),    32'd0);
    chk("reset_count",    32'(count),    32'd0);
    chk("reset_done",     32'(done),     32'd0);
    chk("reset_done_id",  32'(done_id),  32'd0);
    chk("reset_done_why", 32'(done_why), 32'd0);
    chk("reset_tc",       32'(tc),       32'd0);
    rst = 1'b1;

    // All requesting, full leases: rotation 0,1,2,3,0 with minimal gaps.
    for (int i = 0; i < 5; i++) do_round(4'b1111, rand_lv(), LEASE + 5, (i == 0) ? 1 : 2);

    req = '0;
    repeat (2) @(negedge clk);
    lv = rand_lv();
    lv[0*SIZE +: SIZE] = 8'h10;
    do_round(4'b0001, lv, LEASE + 5, 1);          // final 0x1F, lease expiry

    lv = rand_lv();
    lv[2*SIZE +: SIZE] = 8'hFE;
    do_round(4'b0100, lv, LEASE + 5, 2);          // wraps FE, FF, 00 ...

    do_round(4'b0010, rand_lv(), 3, 2);           // drop in 3rd RUN cycle
    do_round(4'b1000, rand_lv(), LEASE, 2);       // drop coincides with lease end
    do_round(4'b0001, rand_lv(), 0, 2);           // drop during LOAD

    for (int i = 0; i < 40; i++) begin
      gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      ew  = 2;
      if (gap > 0) begin
        req = '0;
        repeat (gap) @(negedge clk);
        ew = 1;
      end
      do_round(NREQ'($urandom_range(1, 15)), rand_lv(),
               int'($urandom_range(0, LEASE + 3)), ew);
    end

    // Reset in the middle of a lease: immediate abort, no done.
    req = '0;
    repeat (2) @(negedge clk);
    begin
      grant_exp_t gx;
      int         w, waited;
      lv = rand_lv();
      w  = rr_pick(model_last, 4'b0100);
      gx.g = NREQ'(1) << w;  gx.start = lv[w*SIZE +: SIZE];
      gq.push_back(gx);
      load_val = lv;
      req      = 4'b0100;
      waited   = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (grant == '0 && waited < 10);
      chk("abort_grant_latency", 32'(waited), 32'd1);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_grant", 32'(grant), 32'd0);
      chk("abort_count", 32'(count), 32'd0);
      chk("abort_done",  32'(done),  32'd0);
      chk("abort_tc",    32'(tc),    32'd0);
      req = '0;
      repeat (3) begin
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
      end
    end
    rst = 1'b1;
    model_last = NREQ - 1;
    do_round(4'b1111, rand_lv(), 5, 1);           // requester 0 first again

    req = '0;
    repeat (4) @(negedge clk);
    chk("grant_queue_left", 32'(gq.size()), 32'd0);
    chk("done_queue_left",  32'(dq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tc_counter_arbiter
`default_nettype wire

// File: doc/tc_counter_arbiter.md
TC_COUNTER_ARBITER -- requirements
Module: tc_counter_arbiter

Interface
REQ-001 Parameter SIZE, default 8, counter and load-value width.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter LEASE, default 16, maximum RUN cycles per grant (1..2^16-1).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 req  in  NREQ  per-requester ownership request, level.
REQ-008 load_val  in  NREQ*SIZE  per-requester start value, requester i at bits [i*SIZE +: SIZE].
REQ-009 grant  out  NREQ  one-hot owner, registered.
REQ-010 count  out  SIZE  shared counter value.
REQ-011 tc  out  1  terminal count: high while state RUN and count is all ones.
REQ-012 done  out  1  one-cycle pulse at end of a lease.
REQ-013 done_id  out  clog2(NREQ)  owner index; valid with done.
REQ-014 done_why  out  2  exit cause; valid with done: 0 = req dropped, 1 = lease expired.

Function
REQ-015 FSM states: IDLE, LOAD, RUN, RELEASE; encoding 2 bits.
REQ-016 IDLE: grant = 0; counter save-loaded with 0 each cycle; any req high -> LOAD; winner registered.
REQ-017 Arbitration round-robin: search starts at (last_owner+1) mod NREQ, first set req wins.
REQ-018 grant goes one-hot to the winner on the same edge as IDLE->LOAD.
REQ-019 Latency: req sampled high in IDLE -> grant high next cycle.
REQ-020 LOAD, one cycle: counter loaded with load_val[winner]; lease counter loaded with LEASE-1; -> RUN.
REQ-021 RUN: counter +1 per cycle, wraps all-ones -> 0 silently; lease counter -1 per cycle.
REQ-022 RUN exit: req[owner] sampled low -> RELEASE, why = 0; else lease counter == 0 -> RELEASE, why = 1; req drop wins when both occur.
REQ-023 RELEASE, one cycle: grant = 0; done = 1; done_id = owner; last_owner <= owner; counter holds; -> IDLE.
REQ-024 req changes by non-owners during LOAD/RUN/RELEASE are ignored; arbitration only in IDLE.
REQ-025 req[owner] dropped during LOAD: LOAD still completes; exit detected in the first RUN cycle.
REQ-026 Minimum grant-to-grant gap for back-to-back requesters: 1 IDLE cycle after RELEASE.
REQ-027 count, done, done_id, done_why, grant all registered; tc is the only combinational output.

Reset
REQ-028 rst low: state IDLE; grant 0; count 0; done 0; done_id 0; done_why 0; lease counter 0; last_owner NREQ-1 (so requester 0 wins first).
REQ-029 Reset asserted mid-lease aborts immediately; no done pulse is produced.

Structure
REQ-030 Shared package holds FSM state enum and done_why codes (WHY_DROP, WHY_LEASE).
REQ-031 One sub-module, tc_counter_core: SIZE-bit counter with save/in, increments when save low; arbiter drives save/in.
REQ-032 Round-robin pick and lease counter stay inline in tc_counter_arbiter.

Verification (SIZE=8, NREQ=4, LEASE=16)
REQ-033 req=0b0001, load_val[0]=0x10, held high -> grant=0001 one cycle later; count 0x10, then 0x11...; done with why=1 and done_id=0 after 16 RUN cycles; final count 0x1F.
REQ-034 req=0b1111 held -> grants in order 0001, 0010, 0100, 1000, 0001, with 1-cycle IDLE gaps.
REQ-035 load_val[2]=0xFE, req[2] only -> count FE (tc=0), FF (tc=1), 00 (tc=0); lease continues across wrap.
REQ-036 req[1] dropped in 3rd RUN cycle -> RELEASE next, done_why=0, done_id=1.
REQ-037 Drop req coinciding with lease-counter 0 -> done_why=0.
REQ-038 rst low mid-RUN -> grant=0, count=0 asynchronously; no done; after release, req=0b0001 granted first.
